// File: rtl/otter_arb_pkg.sv
// Shared types and constants for the OTTER memory-bus arbiter.
package otter_arb_pkg;

    localparam int unsigned SIZE_W = 2;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IF   = 2'd1,
        ARB_D    = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

    localparam logic [SIZE_W-1:0] SZ_BYTE = 2'd0;
    localparam logic [SIZE_W-1:0] SZ_HALF = 2'd1;
    localparam logic [SIZE_W-1:0] SZ_WORD = 2'd2;

    // Busy state that serves a given owner.
    function automatic arb_state_t owner_state(input arb_owner_t own);
        return (own == OWN_D) ? ARB_D : ARB_IF;
    endfunction

endpackage

// File: rtl/otter_arb_pick.sv
// Owner selection between fetch and data ports.
// OTTER_ARB_FAIR_EN selects alternating priority; otherwise data has fixed priority.
module otter_arb_pick
    import otter_arb_pkg::*;
(
    input  logic       i_if_req,
    input  logic       i_d_req,
    input  arb_owner_t i_last_own,
    output logic       o_vld,
    output arb_owner_t o_own
);

`ifdef OTTER_ARB_FAIR_EN
    always_comb begin
        o_vld = i_if_req | i_d_req;
        o_own = OWN_IF;
        // On contention the port that did not win last time goes next.
        if (i_if_req && i_d_req) begin
            o_own = (i_last_own == OWN_IF) ? OWN_D : OWN_IF;
        end else if (i_d_req) begin
            o_own = OWN_D;
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = 1'(i_last_own);

    always_comb begin
        o_vld = i_if_req | i_d_req;
        o_own = OWN_IF;
        if (i_d_req) begin
            o_own = OWN_D;
        end
    end
`endif

endmodule

// File: rtl/otter_mem_arbiter.sv
// Single-outstanding arbiter sharing the OTTER memory bus between fetch and data ports.
// Priority scheme chosen by OTTER_ARB_FAIR_EN (see otter_arb_pick).
module otter_mem_arbiter
    import otter_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [SIZE_W-1:0] d_size,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [SIZE_W-1:0] mem_size,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    arb_owner_t        r_last_own;
    arb_owner_t        w_pick_own;
    logic              w_pick_vld;
    logic              w_grant;
    logic              w_done;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [SIZE_W-1:0] r_mem_size;
    logic              r_if_rvalid;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_d_rvalid;
    logic [DATA_W-1:0] r_d_rdata;

    otter_arb_pick u_pick (
        .i_if_req   (if_req),
        .i_d_req    (d_req),
        .i_last_own (r_last_own),
        .o_vld      (w_pick_vld),
        .o_own      (w_pick_own)
    );

    // Grants come only from state and requests, never from mem_ack.
    always_comb begin
        w_state_nxt = r_state;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = owner_state(w_pick_own);
                    if_gnt      = (w_pick_own == OWN_IF);
                    d_gnt       = (w_pick_own == OWN_D);
                end
            end
            ARB_IF, ARB_D: begin
                if (mem_ack) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_grant = if_gnt | d_gnt;
    assign w_done  = (r_state != ARB_IDLE) && mem_ack;

    // Bus request fields, response capture and last-owner tracking.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_size  <= SZ_BYTE;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rvalid  <= 1'b0;
            r_d_rdata   <= '0;
            r_last_own  <= OWN_IF;
        end else begin
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            if (w_grant) begin
                r_mem_req  <= 1'b1;
                r_last_own <= w_pick_own;
                if (w_pick_own == OWN_D) begin
                    r_mem_we    <= d_we;
                    r_mem_addr  <= d_addr;
                    r_mem_wdata <= d_wdata;
                    r_mem_size  <= d_size;
                end else begin
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= if_addr;
                    r_mem_wdata <= '0;
                    r_mem_size  <= SZ_WORD;
                end
            end
            if (w_done) begin
                r_mem_req <= 1'b0;
                if (r_state == ARB_IF) begin
                    r_if_rvalid <= 1'b1;
                    r_if_rdata  <= mem_rdata;
                end else begin
                    // Stores return zero so the pipeline never sees stale bus data.
                    r_d_rvalid <= 1'b1;
                    r_d_rdata  <= r_mem_we ? '0 : mem_rdata;
                end
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_size  = r_mem_size;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;

endmodule

// File: doc/otter_mem_arbiter.md
# otter_mem_arbiter

Shares the single-ported OTTER memory bus between the instruction-fetch port (IF stage) and the data port (MEM stage: loads and stores). It accepts at most one outstanding transaction and holds the request on the bus until memory acknowledges. It returns the response to the owning port with a one-cycle `rvalid` pulse. The pipeline uses `if_gnt`/`d_gnt` and `rvalid` to stall; the block sits between the pipeline stage registers and the memory module.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width

- `CLK`  in  1  system clock, all state on rising edge
- `RST`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch request; held with `if_addr` until `if_gnt`
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  fetch accepted this cycle (combinational)
- `if_rvalid`  out  1  one-cycle pulse, fetch data valid
- `if_rdata`  out  DATA_W  fetched instruction
- `d_req`  in  1  data request; held with the fields below until `d_gnt`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_size`  in  2  0 = byte, 1 = half, 2 = word
- `d_gnt`  out  1  data request accepted this cycle (combinational)
- `d_rvalid`  out  1  one-cycle pulse, load data valid or store complete
- `d_rdata`  out  DATA_W  load data; 0 for stores
- `mem_req`  out  1  bus request, registered
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_size`  out  1/ADDR_W/DATA_W/2  latched request fields, registered
- `mem_ack`  in  1  memory completion; `mem_rdata` valid in the same cycle
- `mem_rdata`  in  DATA_W  memory read data

## Operation
- FSM states are `ARB_IDLE`, `ARB_IF` and `ARB_D`.
- **ARB_IDLE**
  - If there is no request, stay in IDLE.
  - Otherwise pick an owner (see Configuration) and assert the owner's `gnt` combinationally.
  - At the edge, latch the owner's fields into the `mem_*` registers, set `mem_req`=1 and go to `ARB_IF` or `ARB_D`.
- **ARB_IF / ARB_D**
  - Both `gnt` signals are 0.
  - `mem_req` and the `mem_*` fields stay stable until `mem_ack`.
  - On `mem_ack`: capture `mem_rdata` into the owner's rdata register. Stores capture 0; fetches always capture the data.
  - At the same edge: pulse the owner's `rvalid` (next cycle), clear `mem_req` and return to IDLE.
- Only one transaction is outstanding at a time. A request arriving while busy waits; its `gnt` stays 0.
- `if_rdata`/`d_rdata` hold their last captured value between pulses.
- `mem_ack` in IDLE (spurious or late) is ignored: no `rvalid`, no state change.
- `mem_ack` together with a new request from the other port: the ack completes the current owner. The new request is arbitrated in the following IDLE cycle.
- Reset values: state IDLE, `mem_req`=0, `mem_we`=0, all `mem_*` fields 0, both `rvalid`=0, both rdata=0, last-owner=IF.

## Timing
- Accept cycle T: `gnt`=1.
- T+1: `mem_req`=1.
- Ack at cycle A ≥ T+1: `rvalid`=1 at A+1 and state is IDLE at A+1.
- The next `gnt` is possible at A+1, which is the same cycle as the previous `rvalid`.
- Minimum turnaround is 2 cycles per transaction (ack in the same cycle as the first `mem_req`).
- `RST` asserted mid-transaction:
  - At the next edge all outputs take their reset values and `mem_req` drops.
  - The in-flight transaction is abandoned and produces no `rvalid`.
  - An ack after reset is ignored.
- `gnt` depends only on state, `if_req`, `d_req` and the last-owner register. It never depends on `mem_ack`, so there is no bus-to-pipeline combinational path.

## Configuration
- Macro: `OTTER_ARB_FAIR_EN`.
- **Defined (alternating priority):**
  - When both ports request in IDLE, the port that was not the last owner wins.
  - Last-owner updates at every grant.
  - A single requester always wins.
- **Undefined (fixed priority):** data wins whenever `d_req`=1. Last-owner is still kept for debug but does not affect selection.

## Structure
- Package `otter_arb_pkg`:
  - `arb_state_t` enum (`ARB_IDLE`, `ARB_IF`, `ARB_D`)
  - `arb_owner_t` enum (`OWN_IF`, `OWN_D`)
  - size constants `SZ_BYTE`=0, `SZ_HALF`=1, `SZ_WORD`=2
- One sub-module, `otter_arb_pick`: combinational owner selection from `if_req`, `d_req` and last-owner. It holds the only `OTTER_ARB_FAIR_EN`-dependent logic.

## Test plan
- **Single fetch.** `if_req`, addr 0x100, ack after 3 cycles with 0x00000013 → `if_gnt` at T, `mem_req` T+1..T+3, `if_rvalid`=1 with `if_rdata`=0x00000013 at T+4.
- **Store.** `d_req`, `d_we`=1, addr 0x2000, data 0xDEADBEEF, size 2 → `mem_we`=1 and `mem_wdata`=0xDEADBEEF on the bus, `d_rvalid` with `d_rdata`=0 one cycle after ack.
- **Simultaneous requests, both held continuously:**
  - Fixed mode: data granted on every arbitration.
  - Fair mode: grants alternate D, IF, D, IF (last-owner reset = IF, so D goes first).
- **Request while busy.** `if_req` arrives during a D transaction → `if_gnt`=0 until the `rvalid` cycle, then granted in that cycle.
- **Reset mid-transaction.** `RST` asserted while `mem_req`=1 → `mem_req`=0 next cycle, no `rvalid`; a later `mem_ack`=1 in IDLE produces no `rvalid`.
- **Zero-wait memory.** Ack in the first `mem_req` cycle with a back-to-back `if_req` → grant every 2 cycles, each `rvalid` a single-cycle pulse.
